// File: rtl/song_sequencer_pkg.sv
// Shared constants, state encoding and timer sizing for the song sequencer.
package song_sequencer_pkg;

  localparam logic [2:0]  PLAY_MODE        = 3'b011;
  localparam int unsigned END_DUR          = 0;

  localparam int unsigned DEF_ADDR_W       = 8;
  localparam int unsigned DEF_NOTE_W       = 5;
  localparam int unsigned DEF_DUR_W        = 3;
  localparam int unsigned DEF_BEAT_CYCLES  = 12_500_000;
  localparam int unsigned DEF_GAP_CYCLES   = 1_000_000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_PLAY   = 3'd4,
    S_GAP    = 3'd5,
    S_DONE   = 3'd6
  } seq_state_e;

  // Bits needed to hold the longest note, (2^dur_w - 1) beats, without truncation.
  function automatic int unsigned timer_width(input int unsigned dur_w, input int unsigned beat);
    longint unsigned max_ticks;
    max_ticks = ((64'd1 << dur_w) - 64'd1) * 64'(beat);
    return 32'($clog2(max_ticks + 64'd1));
  endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Control, ROM and tone-generator signals of the song sequencer.
interface song_sequencer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned NOTE_W = 5,
  parameter int unsigned DUR_W  = 3
);
  logic [2:0]              mode;
  logic                    pause;
  logic [1:0]              song_num;
  logic [ADDR_W+1:0]       rom_addr;
  logic [NOTE_W+DUR_W-1:0] rom_data;
  logic [NOTE_W-1:0]       note;
  logic                    note_valid;
  logic                    song_done;

  modport master (
    input  mode, pause, song_num, rom_data,
    output rom_addr, note, note_valid, song_done
  );

  modport slave (
    output mode, pause, song_num, rom_data,
    input  rom_addr, note, note_valid, song_done
  );
endinterface

// File: rtl/song_sequencer_note_timer.sv
// Loadable down-counter timing a note body or its articulation gap.
module song_sequencer_note_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         enable,
  output logic         expire_c
);
  logic [W-1:0] count_q, count_d;

  // Clear beats load beats count; a paused timer simply holds.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Expiry on the last counting cycle so the owner can reload in the same edge.
  assign expire_c = enable && (count_q == W'(1));

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/song_sequencer.sv
// Play-mode controller: walks a song's note ROM and times notes and gaps.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned NOTE_W      = DEF_NOTE_W,
  parameter int unsigned DUR_W       = DEF_DUR_W,
  parameter int unsigned BEAT_CYCLES = DEF_BEAT_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  song_sequencer_if.master  bus
);
  localparam int unsigned TIMER_W = timer_width(DUR_W, BEAT_CYCLES);
  localparam int unsigned ROM_W   = NOTE_W + DUR_W;
  localparam int unsigned RA_W    = ADDR_W + 2;

  seq_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   offset_q, offset_d;
  logic [1:0]          song_q, song_d;
  logic [RA_W-1:0]     rom_addr_q, rom_addr_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                note_valid_q, note_valid_d;
  logic                song_done_q, song_done_d;

  logic                tmr_clr, tmr_load, tmr_en, tmr_expire_c;
  logic [TIMER_W-1:0]  tmr_val;
  logic [NOTE_W-1:0]   rom_note_c;
  logic [DUR_W-1:0]    rom_dur_c;

  assign rom_note_c = bus.rom_data[ROM_W-1:DUR_W];
  assign rom_dur_c  = bus.rom_data[DUR_W-1:0];

  song_sequencer_note_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .value    (tmr_val),
    .enable   (tmr_en),
    .expire_c (tmr_expire_c)
  );

  // Next-state, timer control and registered-output values.
  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    song_d     = song_q;
    rom_addr_d = rom_addr_q;
    note_d     = note_q;
    tmr_clr    = 1'b0;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    tmr_val    = '0;

    if (bus.mode != PLAY_MODE) begin
      state_d    = S_IDLE;
      offset_d   = '0;
      song_d     = '0;
      rom_addr_d = '0;
      note_d     = '0;
      tmr_clr    = 1'b1;
    end else if (bus.song_num != song_q) begin
      state_d  = S_FETCH;
      song_d   = bus.song_num;
      offset_d = '0;
      tmr_clr  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_FETCH;
          offset_d = '0;
          song_d   = bus.song_num;
        end
        S_FETCH: begin
          rom_addr_d = {song_q, offset_q};
          state_d    = S_WAIT;
        end
        S_WAIT: state_d = S_DECODE;
        S_DECODE: begin
          if (rom_dur_c == DUR_W'(END_DUR)) begin
            state_d = S_DONE;
          end else begin
            note_d   = rom_note_c;
            tmr_load = 1'b1;
            tmr_val  = TIMER_W'(rom_dur_c) * TIMER_W'(BEAT_CYCLES) - TIMER_W'(GAP_CYCLES);
            state_d  = S_PLAY;
          end
        end
        S_PLAY: begin
          tmr_en = !bus.pause;
          if (tmr_expire_c) begin
            tmr_load = 1'b1;
            tmr_val  = TIMER_W'(GAP_CYCLES);
            state_d  = S_GAP;
          end
        end
        S_GAP: begin
          tmr_en = !bus.pause;
          if (tmr_expire_c) begin
            if (offset_q == '1) begin
              state_d = S_DONE;
            end else begin
              offset_d = offset_q + ADDR_W'(1);
              state_d  = S_FETCH;
            end
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end

    note_valid_d = (state_d == S_PLAY) && (note_d != '0) && !bus.pause;
    song_done_d  = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      offset_q     <= '0;
      song_q       <= '0;
      rom_addr_q   <= '0;
      note_q       <= '0;
      note_valid_q <= 1'b0;
      song_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      song_q       <= song_d;
      rom_addr_q   <= rom_addr_d;
      note_q       <= note_d;
      note_valid_q <= note_valid_d;
      song_done_q  <= song_done_d;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.note       = note_q;
  assign bus.note_valid = note_valid_q;
  assign bus.song_done  = song_done_q;
endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer with a small ROM and a note-run scoreboard.
module tb_song_sequencer;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NOTE_W = 5;
  localparam int unsigned DUR_W  = 3;

  typedef struct {
    int note;
    int len;
    int gap;
  } run_t;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] rom [64];

  int checks = 0;
  int failures = 0;

  run_t exp_q[$];
  run_t obs_q[$];

  int   mon_run_len = 0;
  int   mon_low_len = 0;
  int   mon_run_gap = 0;
  int   mon_run_note = 0;

  song_sequencer_if #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) bus ();

  song_sequencer #(
    .ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W),
    .BEAT_CYCLES(10), .GAP_CYCLES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // Collapse note_valid into runs of {note, length, silent cycles before it}.
  always @(negedge clk) begin
    run_t r;
    if (rst) begin
      mon_run_len = 0;
      mon_low_len = 0;
    end else if (bus.note_valid) begin
      if (mon_run_len == 0) begin
        mon_run_note = int'(bus.note);
        mon_run_gap  = mon_low_len;
      end
      mon_run_len++;
      mon_low_len = 0;
    end else begin
      if (mon_run_len > 0) begin
        r.note = mon_run_note;
        r.len  = mon_run_len;
        r.gap  = mon_run_gap;
        obs_q.push_back(r);
      end
      mon_run_len = 0;
      mon_low_len++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int note, input int len, input int gap);
    run_t r;
    r.note = note;
    r.len  = len;
    r.gap  = gap;
    exp_q.push_back(r);
  endtask

  task automatic wait_note(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.note_valid && bus.note == 5'(n)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_invalid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!bus.note_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.song_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus.rom_addr !== 6'h00) begin failures++; $display("FAIL reset_rom_addr got %h want 00", bus.rom_addr); end
    checks++; if (bus.note !== 5'd0) begin failures++; $display("FAIL reset_note got %0d want 0", bus.note); end
    checks++; if (bus.note_valid !== 1'b0) begin failures++; $display("FAIL reset_note_valid got %b want 0", bus.note_valid); end
    checks++; if (bus.song_done !== 1'b0) begin failures++; $display("FAIL reset_song_done got %b want 0", bus.song_done); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_normal_play();
    bit ok;
    run_t e, o;
    obs_q.delete();
    push_exp(5, 8, -1);
    push_exp(7, 18, 5);
    bus.song_num = 2'd0;
    bus.mode = 3'b011;
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL normal_done_timeout got song_done=%b want 1", bus.song_done); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL normal_run missing, want note %0d len %0d", e.note, e.len);
      end else begin
        o = obs_q.pop_front();
        if (o.note != e.note || o.len != e.len || (e.gap >= 0 && o.gap != e.gap)) begin
          failures++;
          $display("FAIL normal_run got note %0d len %0d gap %0d want note %0d len %0d gap %0d", o.note, o.len, o.gap, e.note, e.len, e.gap);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL normal_extra_runs got %0d want 0", obs_q.size()); end
    repeat (10) tick();
    checks++; if (bus.song_done !== 1'b1 || bus.note_valid !== 1'b0) begin failures++; $display("FAIL normal_done_hold got done=%b valid=%b want 1 0", bus.song_done, bus.note_valid); end
    checks++; if (bus.rom_addr !== 6'h02) begin failures++; $display("FAIL normal_end_addr got %h want 02", bus.rom_addr); end
    bus.mode = 3'b000;
    tick();
  endtask

  task automatic test_pause();
    bit ok;
    run_t e, o;
    obs_q.delete();
    push_exp(5, 8, -1);
    push_exp(7, 4, 5);
    push_exp(7, 14, 5);
    bus.song_num = 2'd0;
    bus.mode = 3'b011;
    wait_note(7, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL pause_note7_timeout got valid=%b note=%0d want 1 7", bus.note_valid, bus.note); end
    repeat (3) tick();
    bus.pause = 1'b1;
    repeat (5) tick();
    bus.pause = 1'b0;
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL pause_done_timeout got song_done=%b want 1", bus.song_done); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL pause_run missing, want note %0d len %0d", e.note, e.len);
      end else begin
        o = obs_q.pop_front();
        if (o.note != e.note || o.len != e.len || (e.gap >= 0 && o.gap != e.gap)) begin
          failures++;
          $display("FAIL pause_run got note %0d len %0d gap %0d want note %0d len %0d gap %0d", o.note, o.len, o.gap, e.note, e.len, e.gap);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL pause_extra_runs got %0d want 0", obs_q.size()); end
    bus.mode = 3'b000;
    tick();
  endtask

  task automatic test_song_change();
    bit ok;
    run_t e, o;
    obs_q.delete();
    push_exp(5, 8, -1);
    push_exp(7, 4, 5);
    push_exp(9, 8, 3);
    bus.song_num = 2'd0;
    bus.mode = 3'b011;
    wait_note(7, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL change_note7_timeout got valid=%b want 1", bus.note_valid); end
    repeat (3) tick();
    bus.song_num = 2'd1;
    tick();
    checks++; if (bus.note_valid !== 1'b0 || bus.song_done !== 1'b0) begin failures++; $display("FAIL change_outputs got valid=%b done=%b want 0 0", bus.note_valid, bus.song_done); end
    tick();
    checks++; if (bus.rom_addr !== 6'h10) begin failures++; $display("FAIL change_rom_addr got %h want 10", bus.rom_addr); end
    wait_done(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL change_done_timeout got song_done=%b want 1", bus.song_done); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL change_run missing, want note %0d len %0d", e.note, e.len);
      end else begin
        o = obs_q.pop_front();
        if (o.note != e.note || o.len != e.len || (e.gap >= 0 && o.gap != e.gap)) begin
          failures++;
          $display("FAIL change_run got note %0d len %0d gap %0d want note %0d len %0d gap %0d", o.note, o.len, o.gap, e.note, e.len, e.gap);
        end
      end
    end
    checks++; if (bus.rom_addr !== 6'h11) begin failures++; $display("FAIL change_end_addr got %h want 11", bus.rom_addr); end
    bus.song_num = 2'd0;
    tick();
    checks++; if (bus.song_done !== 1'b0 || bus.note_valid !== 1'b0) begin failures++; $display("FAIL change_from_done got done=%b valid=%b want 0 0", bus.song_done, bus.note_valid); end
    tick();
    checks++; if (bus.rom_addr !== 6'h00) begin failures++; $display("FAIL change_from_done_addr got %h want 00", bus.rom_addr); end
    bus.mode = 3'b000;
    tick();
  endtask

  task automatic test_mode_exit();
    bit ok;
    bus.song_num = 2'd0;
    bus.mode = 3'b011;
    wait_note(7, 100, ok);
    if (ok) wait_invalid(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL exit_gap_timeout got valid=%b want gap after note 7", bus.note_valid); end
    bus.mode = 3'b000;
    tick();
    checks++; if (bus.note !== 5'd0 || bus.note_valid !== 1'b0) begin failures++; $display("FAIL exit_note got note=%0d valid=%b want 0 0", bus.note, bus.note_valid); end
    checks++; if (bus.rom_addr !== 6'h00 || bus.song_done !== 1'b0) begin failures++; $display("FAIL exit_addr got addr=%h done=%b want 00 0", bus.rom_addr, bus.song_done); end
    repeat (3) tick();
    bus.mode = 3'b011;
    repeat (2) tick();
    checks++; if (bus.rom_addr !== 6'h00 || bus.note_valid !== 1'b0) begin failures++; $display("FAIL reentry_fetch got addr=%h valid=%b want 00 0", bus.rom_addr, bus.note_valid); end
    repeat (2) tick();
    checks++; if (bus.note_valid !== 1'b1 || bus.note !== 5'd5) begin failures++; $display("FAIL reentry_note got valid=%b note=%0d want 1 5", bus.note_valid, bus.note); end
  endtask

  task automatic test_reset_mid_play();
    bit ok;
    wait_note(7, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_timeout got valid=%b want 1", bus.note_valid); end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checks++; if (bus.note !== 5'd0 || bus.note_valid !== 1'b0 || bus.rom_addr !== 6'h00 || bus.song_done !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_outputs got note=%0d valid=%b addr=%h done=%b want 0 0 00 0", bus.note, bus.note_valid, bus.rom_addr, bus.song_done);
    end
    rst = 1'b0;
    bus.mode = 3'b000;
    tick();
  endtask

  task automatic test_rest_no_wrap();
    int seen = 0;
    bit ok = 1'b0;
    bus.song_num = 2'd2;
    bus.mode = 3'b011;
    for (int i = 0; i < 400; i++) begin
      if (bus.song_done) begin
        ok = 1'b1;
        break;
      end
      if (bus.note_valid) seen++;
      tick();
    end
    checks++; if (!ok) begin failures++; $display("FAIL rest_done_timeout got song_done=%b want 1", bus.song_done); end
    checks++; if (seen != 0) begin failures++; $display("FAIL rest_valid_cycles got %0d want 0", seen); end
    checks++; if (bus.rom_addr !== 6'h2F) begin failures++; $display("FAIL rest_end_addr got %h want 2f", bus.rom_addr); end
    bus.pause = 1'b1;
    repeat (5) tick();
    checks++; if (bus.song_done !== 1'b1 || bus.rom_addr !== 6'h2F || bus.note_valid !== 1'b0) begin
      failures++;
      $display("FAIL rest_done_hold got done=%b addr=%h valid=%b want 1 2f 0", bus.song_done, bus.rom_addr, bus.note_valid);
    end
    bus.pause = 1'b0;
    bus.mode = 3'b000;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.mode = 3'b000;
    bus.pause = 1'b0;
    bus.song_num = 2'd0;
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    rom[0]  = {5'd5, 3'd1};
    rom[1]  = {5'd7, 3'd2};
    rom[16] = {5'd9, 3'd1};
    for (int i = 32; i < 48; i++) rom[i] = {5'd0, 3'd1};

    test_reset();
    test_normal_play();
    test_pause();
    test_song_change();
    test_mode_exit();
    test_reset_mid_play();
    test_rest_no_wrap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Playback controller for play mode (mode == 3'b011).
- Walks the note ROM of the selected song and times each note's duration and inter-note silence.
- Drives the note code to the tone generator.
- Consumes pause/song_num from the button controller; owns the ROM address bus and the note_valid qualifier.

Parameters:
ADDR_W, 8, per-song note offset width (2^ADDR_W entries per song)
NOTE_W, 5, note code width; code 0 = rest
DUR_W, 3, duration field width in beat units; 0 = end-of-song marker
BEAT_CYCLES, 12_500_000, clk cycles per beat unit
GAP_CYCLES, 1_000_000, silent articulation cycles at end of each note; must be < BEAT_CYCLES

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock; reset is synchronous and active-high
mode  input  3  global mode; play when 3'b011
pause  input  1  level; 1 = hold playback
song_num  input  2  selected song
rom_addr  output  2+ADDR_W  {song, offset} to note ROM
rom_data  input  NOTE_W+DUR_W  {note, dur}; 1-cycle synchronous ROM
note  output  NOTE_W  current note code
note_valid  output  1  1 = tone generator sounds note
song_done  output  1  end of song reached

Behaviour:
- Reset: state IDLE; rom_addr=0, note=0, note_valid=0, song_done=0; offset, song register and timers cleared. Reset mid-note takes effect next edge.
- States: IDLE, FETCH, WAIT, DECODE, PLAY, GAP, DONE. All registered outputs.
- IDLE: mode==011 -> FETCH with offset=0, song_reg=song_num.
- FETCH: rom_addr <= {song_reg, offset} -> WAIT. rom_addr is held through DECODE.
- WAIT: ROM latency cycle -> DECODE.
- DECODE: sample rom_data.
  - dur==0 -> DONE.
  - Otherwise note <= data note; load timer = dur*BEAT_CYCLES - GAP_CYCLES -> PLAY.
- PLAY: note_valid = (note != 0); timer decrements; at 1 -> load GAP_CYCLES -> GAP.
- GAP: note_valid=0; at timer 1:
  - offset == 2^ADDR_W-1 -> DONE (no wrap).
  - Otherwise offset+1 -> FETCH.
- DONE: song_done=1, note_valid=0; held until song change or mode exit.
- Between notes: note_valid is also 0 during FETCH/WAIT/DECODE (3 cycles).
- Pause:
  - Effective in PLAY/GAP only: timers and state frozen, note_valid forced 0; on release, resume with the remaining count.
  - FETCH/WAIT/DECODE complete normally, then enter PLAY frozen.
  - Pause in DONE has no effect.
- Song change: song_num != song_reg while mode==011, any state:
  - Next cycle: song_reg=song_num, offset=0, note_valid=0, song_done=0 -> FETCH.
  - Has priority over pause and timer expiry.
- Mode exit: mode != 011 in any state -> IDLE next cycle with reset values. Has priority over everything but rst. Re-entry always restarts at offset 0.
- Arithmetic:
  - Timer width ceil(log2((2^DUR_W-1)*BEAT_CYCLES)) unsigned.
  - dur*BEAT_CYCLES computed at full width, no truncation.

Decomposition:
- const.v additions:
  - `PLAY_MODE 3'b011
  - `BEAT_CYCLES, `NOTE_GAP
  - state encodings `SEQ_IDLE..`SEQ_DONE
  - `END_DUR 0
- Sub-module note_timer:
  - load/value/enable down-counter with expire pulse.
  - Used for both PLAY and GAP.

Test Plan:
- Setup for all scenarios: BEAT_CYCLES=10, GAP_CYCLES=2, ADDR_W=4. Song 0 ROM = {5,1},{7,2},{0,0}.
- Normal play: mode=011 -> note=5 valid 8 cycles, 0 for 2+3 cycles; note=7 valid 18 cycles, 0 for 2+3; song_done=1 and stays 1.
- Pause: pause=1 for 5 cycles at 4th cycle of note 7 -> note_valid 0 for those 5 cycles; note 7 still totals 18 valid cycles.
- Song change: song_num 0->1 mid-note 7 -> next cycle note_valid=0, song_done=0; following cycle rom_addr=6'h10.
- Mode exit and re-entry: mode=000 during GAP -> IDLE, all outputs 0; mode=011 again -> rom_addr=6'h00, note 5 replays.
- Reset, rest and no-wrap: rst=1 mid PLAY -> next cycle outputs 0, IDLE. Song 2 of 16 entries {0,1} -> note_valid never 1; after offset 15 -> DONE, rom_addr stays 6'h2F.
